// File: rtl/ddr_test_pkg.sv
// ddr_test_pkg: shared definitions for the DDR clocking stress transmitter
// and the receive-side pattern checker.
//  - checker FSM state encoding
//  - PATTERN_W: width of the toggle counter that drives the DQ pattern
//  - expected_rise(): rise-edge DQ word the transmitter drives for a counter
//    value, so both sides derive the pattern from the same definition.
package ddr_test_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    localparam int PATTERN_W = 8;

    // Widest DQ bus expected_rise() can describe.
    localparam int MAX_DQ_W = 256;

    // Rise word for counter value cnt: DQ[i] = cnt[i % PATTERN_W] for the
    // low dq_width lanes, zero above. dq_width must be a multiple of
    // PATTERN_W, so right-shifting the full replication keeps lane alignment.
    function automatic logic [MAX_DQ_W-1:0] expected_rise(
        input logic [PATTERN_W-1:0] cnt,
        input int                   dq_width
    );
        logic [MAX_DQ_W-1:0] rep;
        rep = {(MAX_DQ_W / PATTERN_W){cnt}};
        return rep >> (MAX_DQ_W - dq_width);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// clr has priority over inc, so a clear on a counting cycle reads 0 next cycle.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next value: clear first, then increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ddr_rx_pattern_checker.sv
// ddr_rx_pattern_checker: locks onto the transmitter's 8-bit toggle-counter
// pattern (rise DQ[i] = cnt[i%8], fall DQ[i] = ~cnt[i%8]) captured by IDDRs
// and reports lock state, sticky per-lane errors and saturating counters.
//
// Build option DDR_CHK_FALL_EN:
//   defined   - fall_dq takes part in the lane mismatch and SEARCH checks.
//   undefined - only rise_dq is checked (half-rate capture bring-up);
//               fall_dq is ignored.
module ddr_rx_pattern_checker
    import ddr_test_pkg::*;
#(
    parameter int DQ_WIDTH    = 16,
    parameter int LOCK_CYCLES = 16,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic                SYS_CLK,
    input  logic                RESET_N,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [DQ_WIDTH-1:0] rise_dq,
    input  logic [DQ_WIDTH-1:0] fall_dq,
    output logic                locked,
    output logic                lock_lost,
    output logic [CNT_W-1:0]    err_count,
    output logic [DQ_WIDTH-1:0] lane_err,
    output logic [31:0]         beat_count
);

    localparam int N_GROUPS = DQ_WIDTH / PATTERN_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    chk_state_e           state_q;
    logic [PATTERN_W-1:0] exp_q;      // counter value expected on this beat
    logic [7:0]           run_q;      // consecutive clean beats toward lock
    logic [7:0]           miss_q;     // consecutive bad beats while locked
    logic                 locked_q;
    logic                 lock_lost_q;
    logic                 lock_lost_d;
    logic [DQ_WIDTH-1:0]  lane_err_q;
    logic [DQ_WIDTH-1:0]  lane_err_d;

    // ------------------------------------------------------------------
    // Expected pattern and per-lane comparison
    // ------------------------------------------------------------------
    logic [MAX_DQ_W-1:0] exp_full;
    logic [DQ_WIDTH-1:0] exp_rise;
    logic                unused_exp_bits;
    logic [DQ_WIDTH-1:0] mm;
    logic                beat_mm;

    assign exp_full        = expected_rise(exp_q, DQ_WIDTH);
    assign exp_rise        = exp_full[DQ_WIDTH-1:0];
    assign unused_exp_bits = ^exp_full;

    genvar gi;
    generate
        for (gi = 0; gi < DQ_WIDTH; gi++) begin : g_lane
`ifdef DDR_CHK_FALL_EN
            assign mm[gi] = (rise_dq[gi] != exp_rise[gi]) |
                            (fall_dq[gi] != ~exp_rise[gi]);
`else
            assign mm[gi] = (rise_dq[gi] != exp_rise[gi]);
`endif
        end
    endgenerate

    assign beat_mm = |mm;

    // ------------------------------------------------------------------
    // SEARCH self-consistency: every byte group repeats rise_dq[7:0] and,
    // when fall checking is built in, fall is the exact complement of rise.
    // ------------------------------------------------------------------
    logic [N_GROUPS-1:0] grp_ok;
    logic                fall_ok;
    logic                consistent;

    generate
        for (gi = 0; gi < N_GROUPS; gi++) begin : g_group
            assign grp_ok[gi] = (rise_dq[gi*PATTERN_W +: PATTERN_W] ==
                                 rise_dq[PATTERN_W-1:0]);
        end
    endgenerate

`ifdef DDR_CHK_FALL_EN
    assign fall_ok = (fall_dq == ~rise_dq);
`else
    logic unused_fall;
    assign fall_ok     = 1'b1;
    assign unused_fall = ^fall_dq;
`endif

    assign consistent = (&grp_ok) & fall_ok;

    // ------------------------------------------------------------------
    // Threshold arithmetic, one bit wider so 255 compares cleanly.
    // ------------------------------------------------------------------
    logic [8:0] run_inc;
    logic [8:0] miss_inc;
    logic       lock_hit;
    logic       loss_hit;

    assign run_inc  = {1'b0, run_q} + 9'd1;
    assign miss_inc = {1'b0, miss_q} + 9'd1;
    assign lock_hit = (run_inc == 9'(LOCK_CYCLES));
    assign loss_hit = (miss_inc == 9'(LOSS_THRESH));

    // Beat qualifiers for the LOCKED-only bookkeeping.
    logic locked_beat;
    logic err_beat;
    logic loss_evt;

    assign locked_beat = in_valid && (state_q == LOCKED);
    assign err_beat    = locked_beat && beat_mm;
    assign loss_evt    = err_beat && loss_hit;

    // ------------------------------------------------------------------
    // Lock FSM: SEARCH -> VERIFY -> LOCKED, with registered locked output.
    // Idle cycles (in_valid low) freeze everything.
    // ------------------------------------------------------------------
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= SEARCH;
            exp_q    <= '0;
            run_q    <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
        end else if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (consistent) begin
                        exp_q   <= rise_dq[PATTERN_W-1:0] + 8'd1;
                        run_q   <= 8'd1;
                        state_q <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (!beat_mm) begin
                        exp_q <= exp_q + 8'd1;
                        run_q <= run_inc[7:0];
                        if (lock_hit) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                            miss_q   <= '0;
                        end
                    end else begin
                        state_q <= SEARCH;
                        run_q   <= '0;
                    end
                end
                LOCKED: begin
                    // exp free-runs so a burst of errors does not shift phase.
                    exp_q <= exp_q + 8'd1;
                    if (!beat_mm) begin
                        miss_q <= '0;
                    end else if (loss_hit) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        miss_q   <= '0;
                        run_q    <= '0;
                    end else begin
                        miss_q <= miss_inc[7:0];
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                    run_q    <= '0;
                    miss_q   <= '0;
                end
            endcase
        end
    end

    // Sticky flags: clear wipes them, but a loss on the same beat still
    // leaves lock_lost set so the event is never hidden.
    always_comb begin
        lane_err_d  = lane_err_q;
        lock_lost_d = lock_lost_q;
        if (clear) begin
            lane_err_d  = '0;
            lock_lost_d = 1'b0;
        end else if (err_beat) begin
            lane_err_d = lane_err_q | mm;
        end
        if (loss_evt) begin
            lock_lost_d = 1'b1;
        end
    end

    // Sticky flag registers.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lane_err_q  <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            lane_err_q  <= lane_err_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturating counters
    // ------------------------------------------------------------------
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .clk   (SYS_CLK),
        .rst_n (RESET_N),
        .clr   (clear),
        .inc   (err_beat),
        .count (err_count)
    );

    sat_counter #(
        .WIDTH (32)
    ) u_beat_cnt (
        .clk   (SYS_CLK),
        .rst_n (RESET_N),
        .clr   (clear),
        .inc   (locked_beat),
        .count (beat_count)
    );

    assign locked    = locked_q;
    assign lock_lost = lock_lost_q;
    assign lane_err  = lane_err_q;

endmodule
